// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus teaching CPU datapath: ALU opcodes,
// bus source codes and instruction-register field positions.
package datapath_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_ADD_1 = 5'b00001;
  localparam logic [4:0] ALU_ADD_2 = 5'b00010;
  localparam logic [4:0] ALU_ADD_3 = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_AND   = 5'b00101;
  localparam logic [4:0] ALU_OR    = 5'b00110;
  localparam logic [4:0] ALU_SHR   = 5'b00111;
  localparam logic [4:0] ALU_SHRA  = 5'b01000;
  localparam logic [4:0] ALU_SHL   = 5'b01001;
  localparam logic [4:0] ALU_ROR   = 5'b01010;
  localparam logic [4:0] ALU_ROL   = 5'b01011;
  localparam logic [4:0] ALU_ADDI  = 5'b01100;
  localparam logic [4:0] ALU_ANDI  = 5'b01101;
  localparam logic [4:0] ALU_ORI   = 5'b01110;
  localparam logic [4:0] ALU_MUL   = 5'b01111;
  localparam logic [4:0] ALU_DIV   = 5'b10000;
  localparam logic [4:0] ALU_NEG   = 5'b10001;
  localparam logic [4:0] ALU_NOT   = 5'b10010;

  localparam logic [4:0] BUS_ZHI  = 5'd16;
  localparam logic [4:0] BUS_ZLO  = 5'd17;
  localparam logic [4:0] BUS_PC   = 5'd18;
  localparam logic [4:0] BUS_MDR  = 5'd19;
  localparam logic [4:0] BUS_C    = 5'd20;
  localparam logic [4:0] BUS_NONE = 5'd31;

  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C_MSB  = 18;

  function automatic logic [3:0] ir_field(input logic [31:0] ir, input int lsb);
    return ir[lsb +: 4];
  endfunction

  function automatic logic [31:0] ir_const(input logic [31:0] ir);
    return {{13{ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
// Only mul/div produce a non-zero high word.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [63:0] result
);

  logic [4:0]  sh_s;
  logic [31:0] shra_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  assign sh_s   = b[4:0];
  assign shra_s = $signed(a) >>> sh_s;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Signed divide; a zero divisor yields zero quotient and remainder
  always_comb begin
    quot_s = 32'h0;
    rem_s  = 32'h0;
    if (b == 32'h0) begin
      quot_s = 32'h0;
      rem_s  = 32'h0;
    end else begin
      quot_s = $signed(a) / $signed(b);
      rem_s  = $signed(a) % $signed(b);
    end
  end

  // Opcode decode
  always_comb begin
    result = 64'h0;
    case (op)
      ALU_ADD, ALU_ADD_1, ALU_ADD_2, ALU_ADD_3, ALU_ADDI:
                         result = {32'h0, a + b};
      ALU_SUB:           result = {32'h0, a - b};
      ALU_AND, ALU_ANDI: result = {32'h0, a & b};
      ALU_OR, ALU_ORI:   result = {32'h0, a | b};
      ALU_SHR:           result = {32'h0, a >> sh_s};
      ALU_SHRA:          result = {32'h0, shra_s};
      ALU_SHL:           result = {32'h0, a << sh_s};
      // 5-bit wrap of (0 - sh) gives 32 - sh, and 0 when sh is 0
      ALU_ROR:           result = {32'h0, (a >> sh_s) | (a << (5'd0 - sh_s))};
      ALU_ROL:           result = {32'h0, (a << sh_s) | (a >> (5'd0 - sh_s))};
      ALU_MUL:           result = prod_s;
      ALU_DIV:           result = {rem_s, quot_s};
      ALU_NEG:           result = {32'h0, 32'h0 - a};
      ALU_NOT:           result = {32'h0, ~a};
      default:           result = 64'h0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, bus mux, ALU and on-chip RAM.
// Define DATAPATH_MEM_WRITE_EN to add the `write` port for RAM stores from MDR.
module datapath
  import datapath_pkg::*;
#(
  parameter int    MEM_DEPTH     = 512,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        clear,
`ifdef DATAPATH_MEM_WRITE_EN
  input  logic        write,
`endif
  input  logic        PC_enable,
  input  logic        PC_increment_enable,
  input  logic        IR_enable,
  input  logic        Y_enable,
  input  logic        Z_enable,
  input  logic        MAR_enable,
  input  logic        MDR_enable,
  input  logic        r_enable,
  input  logic        read,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        PC_select,
  input  logic        Z_HI_select,
  input  logic        Z_LO_select,
  input  logic        MDR_select,
  input  logic        c_select,
  input  logic [4:0]  alu_instruction,
  output logic [4:0]  bus_select,
  output logic [31:0] bus_Data,
  output logic [31:0] R0_Data,
  output logic [31:0] R1_Data,
  output logic [31:0] PC_Data,
  output logic [31:0] IR_Data,
  output logic [31:0] Y_Data,
  output logic [31:0] Z_HI_Data,
  output logic [31:0] Z_LO_Data,
  output logic [31:0] MAR_Data,
  output logic [31:0] MDR_Data,
  output logic [31:0] MDataIN
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic [31:0]       regs_r [16];
  logic [31:0]       pc_r, ir_r, y_r, z_hi_r, z_lo_r, mar_r, mdr_r;
  logic [31:0]       mem_r [MEM_DEPTH];
  logic [3:0]        reg_idx_s;
  logic [4:0]        bus_select_s;
  logic [31:0]       bus_data_s;
  logic [31:0]       c_s;
  logic [63:0]       alu_result_s;
  logic [ADDR_W-1:0] mem_addr_s;

  assign c_s        = ir_const(ir_r);
  assign mem_addr_s = mar_r[ADDR_W-1:0];

  // Register index from IR fields, Gra taking precedence over Grb over Grc
  always_comb begin
    reg_idx_s = 4'h0;
    if (Gra) begin
      reg_idx_s = ir_field(ir_r, IR_RA_LSB);
    end else if (Grb) begin
      reg_idx_s = ir_field(ir_r, IR_RB_LSB);
    end else if (Grc) begin
      reg_idx_s = ir_field(ir_r, IR_RC_LSB);
    end else begin
      reg_idx_s = 4'h0;
    end
  end

  // Bus source encoder
  always_comb begin
    bus_select_s = BUS_NONE;
    if (PC_select) begin
      bus_select_s = BUS_PC;
    end else if (MDR_select) begin
      bus_select_s = BUS_MDR;
    end else if (Z_LO_select) begin
      bus_select_s = BUS_ZLO;
    end else if (Z_HI_select) begin
      bus_select_s = BUS_ZHI;
    end else if (c_select) begin
      bus_select_s = BUS_C;
    end else if (Rout || BAout) begin
      bus_select_s = {1'b0, reg_idx_s};
    end else begin
      bus_select_s = BUS_NONE;
    end
  end

  // Bus multiplexer; BAout reads R0 as zero for base-address arithmetic
  always_comb begin
    bus_data_s = 32'h0;
    case (bus_select_s)
      BUS_ZHI:  bus_data_s = z_hi_r;
      BUS_ZLO:  bus_data_s = z_lo_r;
      BUS_PC:   bus_data_s = pc_r;
      BUS_MDR:  bus_data_s = mdr_r;
      BUS_C:    bus_data_s = c_s;
      BUS_NONE: bus_data_s = 32'h0;
      default:  bus_data_s = (BAout && reg_idx_s == 4'h0) ? 32'h0 : regs_r[reg_idx_s];
    endcase
  end

  datapath_alu u_alu (
    .a      (y_r),
    .b      (bus_data_s),
    .op     (alu_instruction),
    .result (alu_result_s)
  );

  // General-purpose register file
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 32'h0;
    end else if (r_enable) begin
      regs_r[reg_idx_s] <= bus_data_s;
    end
  end

  // Special-purpose registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pc_r   <= 32'h0;
      ir_r   <= 32'h0;
      y_r    <= 32'h0;
      z_hi_r <= 32'h0;
      z_lo_r <= 32'h0;
      mar_r  <= 32'h0;
      mdr_r  <= 32'h0;
    end else begin
      if (PC_enable)                pc_r <= bus_data_s;
      else if (PC_increment_enable) pc_r <= pc_r + 32'd1;
      if (IR_enable)  ir_r  <= bus_data_s;
      if (Y_enable)   y_r   <= bus_data_s;
      if (MAR_enable) mar_r <= bus_data_s;
      if (MDR_enable) mdr_r <= read ? MDataIN : bus_data_s;
      if (Z_enable) begin
        z_hi_r <= alu_result_s[63:32];
        z_lo_r <= alu_result_s[31:0];
      end
    end
  end

`ifdef DATAPATH_MEM_WRITE_EN
  // RAM store port
  always_ff @(posedge clk) begin
    if (write) mem_r[mem_addr_s] <= mdr_r;
  end
`endif

  assign MDataIN    = mem_r[mem_addr_s];
  assign bus_select = bus_select_s;
  assign bus_Data   = bus_data_s;
  assign R0_Data    = regs_r[0];
  assign R1_Data    = regs_r[1];
  assign PC_Data    = pc_r;
  assign IR_Data    = ir_r;
  assign Y_Data     = y_r;
  assign Z_HI_Data  = z_hi_r;
  assign Z_LO_Data  = z_lo_r;
  assign MAR_Data   = mar_r;
  assign MDR_Data   = mdr_r;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: micro-step stimulus pushes expectations tagged
// with the cycle they become visible; a negedge monitor pops and compares them.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clear;
  logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic        MAR_enable, MDR_enable, r_enable, read;
  logic        Gra, Grb, Grc, Rout, BAout;
  logic        PC_select, Z_HI_select, Z_LO_select, MDR_select, c_select;
  logic [4:0]  alu_instruction;
  logic [4:0]  bus_select;
  logic [31:0] bus_Data, R0_Data, R1_Data, PC_Data, IR_Data, Y_Data;
  logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data, MDataIN;

  datapath dut (
    .clk(clk), .clear(clear),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .BAout(BAout),
    .PC_select(PC_select), .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .c_select(c_select),
    .alu_instruction(alu_instruction),
    .bus_select(bus_select), .bus_Data(bus_Data),
    .R0_Data(R0_Data), .R1_Data(R1_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
    .Y_Data(Y_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data),
    .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .MDataIN(MDataIN)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_BUS = 0, S_SEL = 1, S_R0 = 2, S_R1 = 3, S_PC = 4, S_IR = 5;
  localparam int S_Y = 6, S_ZHI = 7, S_ZLO = 8, S_MAR = 9, S_MDR = 10, S_MDIN = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  // Reference model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_ir;
  logic [31:0] m_mem [512];

  function automatic logic [31:0] dut_sig(input int s);
    logic [31:0] v;
    case (s)
      S_BUS:   v = bus_Data;
      S_SEL:   v = {27'h0, bus_select};
      S_R0:    v = R0_Data;
      S_R1:    v = R1_Data;
      S_PC:    v = PC_Data;
      S_IR:    v = IR_Data;
      S_Y:     v = Y_Data;
      S_ZHI:   v = Z_HI_Data;
      S_ZLO:   v = Z_LO_Data;
      S_MAR:   v = MAR_Data;
      S_MDR:   v = MDR_Data;
      S_MDIN:  v = MDataIN;
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  // Behavioural ALU: plain integer arithmetic, rotates one bit at a time
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, sh;
    longint      p;
    logic [31:0] r;
    logic [63:0] res;
    sa = a; sb = b; sh = int'(b[4:0]); r = a; res = 64'h0;
    case (int'(op))
      0, 1, 2, 3, 12: res = {32'h0, a + b};
      4:       res = {32'h0, a - b};
      5, 13:   res = {32'h0, a & b};
      6, 14:   res = {32'h0, a | b};
      7:       res = {32'h0, a >> sh};
      8:       res = {32'h0, 32'(sa >>> sh)};
      9:       res = {32'h0, a << sh};
      10: begin repeat (sh) r = {r[0], r[31:1]}; res = {32'h0, r}; end
      11: begin repeat (sh) r = {r[30:0], r[31]}; res = {32'h0, r}; end
      15: begin p = longint'(sa) * longint'(sb); res = 64'(p); end
      16:      res = (sb == 0) ? 64'h0 : {32'(sa % sb), 32'(sa / sb)};
      17:      res = {32'h0, 32'(-sa)};
      18:      res = {32'h0, ~a};
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  task automatic push_chk(input int when, input int s, input logic [31:0] v, input string n);
    chk_t c;
    c.cyc = when; c.sig = s; c.exp = v; c.name = n;
    sb_q.push_back(c);
  endtask

  task automatic expect_now(input int s, input logic [31:0] v, input string n);
    push_chk(cyc, s, v, n);
  endtask

  task automatic expect_next(input int s, input logic [31:0] v, input string n);
    push_chk(cyc + 1, s, v, n);
  endtask

  task automatic ctl_idle();
    {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable} = 5'b0;
    {MAR_enable, MDR_enable, r_enable, read} = 4'b0;
    {Gra, Grb, Grc, Rout, BAout} = 5'b0;
    {PC_select, Z_HI_select, Z_LO_select, MDR_select, c_select} = 5'b0;
    alu_instruction = 5'b0;
  endtask

  // Start a micro-step: controls are driven 2ns after the active edge
  task automatic step_begin();
    @(posedge clk);
    #2;
    ctl_idle();
  endtask

  task automatic expect_reset_state();
    for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
    {m_pc, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_ir} = '0;
    expect_now(S_SEL, 32'd31, "rst_bus_select");
    expect_now(S_BUS, 32'h0, "rst_bus");
    expect_now(S_R0, 32'h0, "rst_r0");
    expect_now(S_R1, 32'h0, "rst_r1");
    expect_now(S_PC, 32'h0, "rst_pc");
    expect_now(S_IR, 32'h0, "rst_ir");
    expect_now(S_Y, 32'h0, "rst_y");
    expect_now(S_ZHI, 32'h0, "rst_zhi");
    expect_now(S_ZLO, 32'h0, "rst_zlo");
    expect_now(S_MAR, 32'h0, "rst_mar");
    expect_now(S_MDR, 32'h0, "rst_mdr");
  endtask

  // MAR <- PC, then MDR <- RAM[MAR] with PC incremented
  task automatic fetch();
    step_begin();
    PC_select = 1'b1; MAR_enable = 1'b1;
    expect_now(S_SEL, 32'd18, "fetch_sel_pc");
    expect_now(S_BUS, m_pc, "fetch_bus_pc");
    m_mar = m_pc;
    expect_next(S_MAR, m_mar, "fetch_mar");
    step_begin();
    PC_increment_enable = 1'b1; read = 1'b1; MDR_enable = 1'b1;
    expect_now(S_MDIN, m_mem[m_mar[8:0]], "fetch_mdatain");
    m_mdr = m_mem[m_mar[8:0]];
    m_pc  = m_pc + 32'd1;
    expect_next(S_MDR, m_mdr, "fetch_mdr");
    expect_next(S_PC, m_pc, "fetch_pc");
  endtask

  // ldi Ra, C(Rb): Ra <= (Rb==0 ? 0 : R[Rb]) + C
  task automatic ldi_exec();
    logic [3:0]  rb, ra;
    logic [31:0] c;
    fetch();
    step_begin();
    MDR_select = 1'b1; IR_enable = 1'b1;
    expect_now(S_SEL, 32'd19, "ldi_sel_mdr");
    m_ir = m_mdr;
    expect_next(S_IR, m_ir, "ldi_ir");
    step_begin();
    Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
    rb  = m_ir[22:19];
    m_y = (rb == 4'h0) ? 32'h0 : m_r[rb];
    expect_now(S_BUS, m_y, "ldi_base");
    expect_next(S_Y, m_y, "ldi_y");
    step_begin();
    c_select = 1'b1; alu_instruction = 5'b00001; Z_enable = 1'b1;
    c = {{13{m_ir[18]}}, m_ir[18:0]};
    expect_now(S_BUS, c, "ldi_c");
    m_zlo = m_y + c; m_zhi = 32'h0;
    expect_next(S_ZLO, m_zlo, "ldi_zlo");
    expect_next(S_ZHI, m_zhi, "ldi_zhi");
    step_begin();
    Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
    ra = m_ir[26:23];
    m_r[ra] = m_zlo;
    expect_now(S_BUS, m_zlo, "ldi_bus_zlo");
    expect_next(S_R0, m_r[0], "ldi_r0");
    expect_next(S_R1, m_r[1], "ldi_r1");
  endtask

  // Scoreboard monitor: compares every expectation due in the current cycle
  initial begin
    chk_t c;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        c = sb_q.pop_front();
        checks = checks + 1;
        got = dut_sig(c.sig);
        if (c.cyc != cyc) begin
          failures = failures + 1;
          $display("FAIL %s: not compared in cycle %0d (now %0d)", c.name, c.cyc, cyc);
        end else if (got !== c.exp) begin
          failures = failures + 1;
          $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, got, c.exp, cyc);
        end
      end
      if (stim_done) begin
        while (sb_q.size() > 0) begin
          c = sb_q.pop_front();
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL %s: never observed, expected %h", c.name, c.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [63:0] res;
    ctl_idle();
    clear = 1'b1;
    for (int i = 0; i < 512; i++) m_mem[i] = $urandom();
    m_mem[0] = 32'h0880_0054;
    m_mem[1] = 32'h0808_0005;
    m_mem[2] = 32'hFFFF_FFFA;
    m_mem[3] = 32'h0000_0004;
    m_mem[4] = 32'h0000_0000;
    m_mem[5] = 32'h0000_0010;
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 1) m_mem[17 + 2 * k] = 32'($urandom_range(0, 40));
      if (k % 7 == 0) m_mem[17 + 2 * k] = 32'h0;
      if (m_mem[16 + 2 * k] == 32'h8000_0000 && m_mem[17 + 2 * k] == 32'hFFFF_FFFF)
        m_mem[17 + 2 * k] = 32'h1;
    end
    for (int i = 0; i < 512; i++) dut.mem_r[i] = m_mem[i];

    step_begin();
    expect_reset_state();
    step_begin();
    clear = 1'b0;

    // ldi R1,0x54 then ldi R0,5(R1)
    ldi_exec();
    expect_next(S_R1, 32'h0000_0054, "ldi1_r1_const");
    expect_next(S_PC, 32'h0000_0001, "ldi1_pc_const");
    ldi_exec();
    expect_next(S_R0, 32'h0000_0059, "ldi2_r0_const");
    expect_next(S_PC, 32'h0000_0002, "ldi2_pc_const");

    // R0 through BAout reads as zero, through Rout as its contents
    step_begin();
    Gra = 1'b1; BAout = 1'b1;
    expect_now(S_SEL, 32'd0, "baout_sel");
    expect_now(S_BUS, 32'h0, "baout_r0_zero");
    step_begin();
    Gra = 1'b1; Rout = 1'b1;
    expect_now(S_BUS, 32'h0000_0059, "rout_r0");

    // mul/div of -6 by 4, then divide by zero
    fetch();
    step_begin();
    MDR_select = 1'b1; Y_enable = 1'b1;
    m_y = m_mdr;
    expect_next(S_Y, 32'hFFFF_FFFA, "y_minus6");
    fetch();
    step_begin();
    MDR_select = 1'b1; alu_instruction = 5'b01111; Z_enable = 1'b1;
    expect_now(S_BUS, 32'h4, "mul_bus");
    expect_next(S_ZHI, 32'hFFFF_FFFF, "mul_zhi");
    expect_next(S_ZLO, 32'hFFFF_FFE8, "mul_zlo");
    step_begin();
    MDR_select = 1'b1; alu_instruction = 5'b10000; Z_enable = 1'b1;
    expect_next(S_ZLO, 32'hFFFF_FFFF, "div_quot");
    expect_next(S_ZHI, 32'hFFFF_FFFE, "div_rem");
    fetch();
    step_begin();
    MDR_select = 1'b1; alu_instruction = 5'b10000; Z_enable = 1'b1;
    expect_next(S_ZLO, 32'h0, "div0_zlo");
    expect_next(S_ZHI, 32'h0, "div0_zhi");

    // Load wins over increment
    fetch();
    step_begin();
    MDR_select = 1'b1; PC_enable = 1'b1; PC_increment_enable = 1'b1;
    m_pc = m_mdr;
    expect_next(S_PC, 32'h0000_0010, "pc_load_priority");

    // Randomised ALU operations against the reference model
    for (int k = 0; k < 30; k++) begin
      fetch();
      step_begin();
      MDR_select = 1'b1; Y_enable = 1'b1;
      m_y = m_mdr;
      expect_next(S_Y, m_y, "rnd_y");
      fetch();
      op = 5'($urandom_range(0, 31));
      step_begin();
      MDR_select = 1'b1; alu_instruction = op; Z_enable = 1'b1;
      res = ref_alu(op, m_y, m_mdr);
      m_zhi = res[63:32]; m_zlo = res[31:0];
      expect_now(S_BUS, m_mdr, "rnd_bus_b");
      expect_next(S_ZHI, m_zhi, "rnd_zhi");
      expect_next(S_ZLO, m_zlo, "rnd_zlo");
      step_begin();
      Z_HI_select = 1'b1;
      if (k % 3 == 0) c_select = 1'b1;
      expect_now(S_SEL, 32'd16, "rnd_sel_zhi");
      expect_now(S_BUS, m_zhi, "rnd_bus_zhi");
    end

    // Asynchronous clear mid-run
    step_begin();
    clear = 1'b1;
    expect_reset_state();
    step_begin();
    clear = 1'b0;
    repeat (3) @(posedge clk);
    stim_done = 1'b1;
  end

endmodule
